// File: rtl/dsp_rdata_ordered_channel.sv
// In-order R-channel dispatcher for one master port: per-slave beat
// FIFOs, an AR-order queue, and a one-entry registered output stage.
module dsp_rdata_ordered_channel #(
   parameter int SLV_AMT         = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int RESP_W          = 2,
   parameter int SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
   parameter int DSP_RDATA_DEPTH = 16,
   parameter int DSP_ORDER_DEPTH = 8
) (
   input  logic                                 ACLK_i,
   input  logic                                 ARESET_i,
   input  logic                                 dsp_AR_push_i,
   input  logic [SLV_ID_W-1:0]                  dsp_AR_slv_id_i,
   output logic                                 dsp_AR_ready_o,
   input  logic                                 dsp_R_disable_i,
   input  logic [SLV_AMT*TRANS_MST_ID_W-1:0]    sa_RID_i,
   input  logic [SLV_AMT*DATA_WIDTH-1:0]        sa_RDATA_i,
   input  logic [SLV_AMT*RESP_W-1:0]            sa_RRESP_i,
   input  logic [SLV_AMT-1:0]                   sa_RLAST_i,
   input  logic [SLV_AMT-1:0]                   sa_RVALID_i,
   output logic [SLV_AMT-1:0]                   sa_RREADY_o,
   output logic [TRANS_MST_ID_W-1:0]            m_RID_o,
   output logic [DATA_WIDTH-1:0]                m_RDATA_o,
   output logic [RESP_W-1:0]                    m_RRESP_o,
   output logic                                 m_RLAST_o,
   output logic                                 m_RVALID_o,
   input  logic                                 m_RREADY_i,
   output logic                                 dsp_R_handshake_occur_o,
   output logic                                 dsp_R_last_done_o,
   output logic [$clog2(DSP_ORDER_DEPTH+1)-1:0] dsp_R_outstanding_o
);
   localparam int EW = TRANS_MST_ID_W + DATA_WIDTH + RESP_W + 1;
   localparam int FA = $clog2(DSP_RDATA_DEPTH);
   localparam int OA = $clog2(DSP_ORDER_DEPTH);
   localparam int CW = $clog2(DSP_ORDER_DEPTH + 1);

   logic [EW-1:0]       fifo_head [SLV_AMT];
   logic [SLV_AMT-1:0]  fifo_empty;
   logic [SLV_AMT-1:0]  fifo_full;
   logic [SLV_AMT-1:0]  fifo_pop;

   logic [SLV_ID_W-1:0] oq_mem [DSP_ORDER_DEPTH];
   logic [OA:0]         oq_wptr;
   logic [OA:0]         oq_rptr;
   logic [OA:0]         oq_count;
   logic                oq_empty;
   logic                oq_full;
   logic                oq_push;
   logic                oq_pop;
   logic [SLV_ID_W-1:0] oq_head;

   logic [EW-1:0]       head_beat;
   logic [EW-1:0]       out_beat;
   logic                out_valid;
   logic                hs;
   logic                load;

   for (genvar k = 0; k < SLV_AMT; k++) begin : g_slv
      logic [EW-1:0] mem [DSP_RDATA_DEPTH];
      logic [FA:0]   wptr;
      logic [FA:0]   rptr;
      logic          wr;

      assign wr            = sa_RVALID_i[k] & ~fifo_full[k];
      assign fifo_empty[k] = (wptr == rptr);
      assign fifo_full[k]  = (wptr[FA] != rptr[FA]) &&
                             (wptr[FA-1:0] == rptr[FA-1:0]);
      assign fifo_head[k]  = mem[rptr[FA-1:0]];
      assign fifo_pop[k]   = load && (oq_head == SLV_ID_W'(k));

      // beat FIFO pointers; the extra MSB separates full from empty
      always_ff @(posedge ACLK_i) begin
         if (ARESET_i) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr)
               wptr <= wptr + (FA+1)'(1);
            if (fifo_pop[k])
               rptr <= rptr + (FA+1)'(1);
         end
      end

      // beat storage as {RID, RDATA, RRESP, RLAST}
      always_ff @(posedge ACLK_i) begin
         if (wr)
            mem[wptr[FA-1:0]] <= {
               sa_RID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W],
               sa_RDATA_i[k*DATA_WIDTH +: DATA_WIDTH],
               sa_RRESP_i[k*RESP_W +: RESP_W],
               sa_RLAST_i[k]};
      end
   end

   assign sa_RREADY_o = ~fifo_full;

   assign oq_count = oq_wptr - oq_rptr;
   assign oq_empty = (oq_wptr == oq_rptr);
   assign oq_full  = (oq_wptr[OA] != oq_rptr[OA]) &&
                     (oq_wptr[OA-1:0] == oq_rptr[OA-1:0]);
   assign oq_head  = oq_mem[oq_rptr[OA-1:0]];
   assign oq_push  = dsp_AR_push_i & ~oq_full;
   assign oq_pop   = load & head_beat[0];

   assign head_beat = fifo_head[oq_head];
   assign hs        = out_valid & m_RREADY_i;
   assign load      = ~oq_empty & ~fifo_empty[oq_head] &
                      ~dsp_R_disable_i & (~out_valid | m_RREADY_i);

   // order-queue pointers; a push while full is dropped
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         oq_wptr <= '0;
         oq_rptr <= '0;
      end else begin
         if (oq_push)
            oq_wptr <= oq_wptr + (OA+1)'(1);
         if (oq_pop)
            oq_rptr <= oq_rptr + (OA+1)'(1);
      end
   end

   // order-queue storage of slave ids in AR-issue order
   always_ff @(posedge ACLK_i) begin
      if (oq_push)
         oq_mem[oq_wptr[OA-1:0]] <= dsp_AR_slv_id_i;
   end

   // output stage: load replaces the held beat, a bare handshake empties it
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         out_valid <= 1'b0;
         out_beat  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_beat  <= head_beat;
      end else if (hs) begin
         out_valid <= 1'b0;
      end
   end

   assign {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o} = out_beat;
   assign m_RVALID_o              = out_valid;
   assign dsp_AR_ready_o          = ~oq_full;
   assign dsp_R_handshake_occur_o = hs;
   assign dsp_R_last_done_o       = hs & m_RLAST_o;
   assign dsp_R_outstanding_o     = CW'(oq_count);

endmodule

// File: tb/tb_dsp_rdata_ordered_channel.sv
// Bench for dsp_rdata_ordered_channel: directed scenarios and random
// traffic, all checked against a queue-based cycle model.
module tb_dsp_rdata_ordered_channel;
   localparam int SLV = 4;
   localparam int DW  = 64;
   localparam int IW  = 5;
   localparam int RW  = 2;
   localparam int FD  = 16;
   localparam int OD  = 8;
   localparam int EW  = IW + DW + RW + 1;

   typedef logic [EW-1:0] beat_t;

   logic             clk = 1'b0;
   logic             ARESET_i;
   logic             dsp_AR_push_i;
   logic [1:0]       dsp_AR_slv_id_i;
   logic             dsp_AR_ready_o;
   logic             dsp_R_disable_i;
   logic [SLV*IW-1:0] sa_RID_i;
   logic [SLV*DW-1:0] sa_RDATA_i;
   logic [SLV*RW-1:0] sa_RRESP_i;
   logic [SLV-1:0]   sa_RLAST_i;
   logic [SLV-1:0]   sa_RVALID_i;
   logic [SLV-1:0]   sa_RREADY_o;
   logic [IW-1:0]    m_RID_o;
   logic [DW-1:0]    m_RDATA_o;
   logic [RW-1:0]    m_RRESP_o;
   logic             m_RLAST_o;
   logic             m_RVALID_o;
   logic             m_RREADY_i;
   logic             dsp_R_handshake_occur_o;
   logic             dsp_R_last_done_o;
   logic [3:0]       dsp_R_outstanding_o;

   beat_t in_beat [SLV];

   dsp_rdata_ordered_channel #(
      .SLV_AMT(SLV), .DATA_WIDTH(DW), .TRANS_MST_ID_W(IW),
      .RESP_W(RW), .SLV_ID_W(2),
      .DSP_RDATA_DEPTH(FD), .DSP_ORDER_DEPTH(OD)
   ) dut (
      .ACLK_i(clk),
      .ARESET_i(ARESET_i),
      .dsp_AR_push_i(dsp_AR_push_i),
      .dsp_AR_slv_id_i(dsp_AR_slv_id_i),
      .dsp_AR_ready_o(dsp_AR_ready_o),
      .dsp_R_disable_i(dsp_R_disable_i),
      .sa_RID_i(sa_RID_i),
      .sa_RDATA_i(sa_RDATA_i),
      .sa_RRESP_i(sa_RRESP_i),
      .sa_RLAST_i(sa_RLAST_i),
      .sa_RVALID_i(sa_RVALID_i),
      .sa_RREADY_o(sa_RREADY_o),
      .m_RID_o(m_RID_o),
      .m_RDATA_o(m_RDATA_o),
      .m_RRESP_o(m_RRESP_o),
      .m_RLAST_o(m_RLAST_o),
      .m_RVALID_o(m_RVALID_o),
      .m_RREADY_i(m_RREADY_i),
      .dsp_R_handshake_occur_o(dsp_R_handshake_occur_o),
      .dsp_R_last_done_o(dsp_R_last_done_o),
      .dsp_R_outstanding_o(dsp_R_outstanding_o)
   );

   always #5 clk = ~clk;

   // spread the per-slave bench beats onto the packed input buses
   always_comb begin
      sa_RID_i   = '0;
      sa_RDATA_i = '0;
      sa_RRESP_i = '0;
      sa_RLAST_i = '0;
      for (int k = 0; k < SLV; k++) begin
         sa_RID_i[k*IW +: IW]   = in_beat[k][EW-1 -: IW];
         sa_RDATA_i[k*DW +: DW] = in_beat[k][DW+RW:RW+1];
         sa_RRESP_i[k*RW +: RW] = in_beat[k][RW:1];
         sa_RLAST_i[k]          = in_beat[k][0];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   beat_t       mf [SLV][$];
   logic [1:0]  mo [$];
   logic        ov;
   beat_t       ob;

   logic [DW-1:0] got_d [$];
   int            got_c [$];
   int            n_last;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   function automatic beat_t mk(input logic [IW-1:0] id,
                                input logic [DW-1:0] d,
                                input logic [RW-1:0] r,
                                input logic l);
      return {id, d, r, l};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < SLV; k++)
         mf[k].delete();
      mo.delete();
      ov = 1'b0;
      ob = '0;
   endtask

   task automatic compare();
      logic [SLV-1:0] rdy;
      for (int k = 0; k < SLV; k++)
         rdy[k] = (mf[k].size() < FD);
      chk("arready", dsp_AR_ready_o, mo.size() < OD);
      chk("rready", sa_RREADY_o, rdy);
      chk("outst", dsp_R_outstanding_o, mo.size());
      chk("rvalid", m_RVALID_o, ov);
      if (ov)
         chk("rbeat", {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o}, ob);
      chk("hs", dsp_R_handshake_occur_o, ov && m_RREADY_i);
      chk("ldone", dsp_R_last_done_o, ov && m_RREADY_i && ob[0]);
   endtask

   task automatic step();
      logic [SLV-1:0] rdy;
      logic ard, hs, ld;
      int h;
      if (ARESET_i) begin
         model_reset();
         return;
      end
      for (int k = 0; k < SLV; k++)
         rdy[k] = (mf[k].size() < FD);
      ard = (mo.size() < OD);
      hs  = ov && m_RREADY_i;
      ld  = 1'b0;
      h   = 0;
      if (mo.size() > 0) begin
         h  = int'(mo[0]);
         ld = (mf[h].size() > 0) && !dsp_R_disable_i && (!ov || hs);
      end
      if (ld) begin
         ob = mf[h].pop_front();
         ov = 1'b1;
         if (ob[0])
            void'(mo.pop_front());
      end else if (hs) begin
         ov = 1'b0;
      end
      for (int k = 0; k < SLV; k++)
         if (sa_RVALID_i[k] && rdy[k])
            mf[k].push_back(in_beat[k]);
      if (dsp_AR_push_i && ard)
         mo.push_back(dsp_AR_slv_id_i);
   endtask

   task automatic cycle();
      #1;
      compare();
      if (m_RVALID_o && m_RREADY_i) begin
         got_d.push_back(m_RDATA_o);
         got_c.push_back(cyc);
         if (m_RLAST_o)
            n_last++;
      end
      step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_got();
      got_d.delete();
      got_c.delete();
      n_last = 0;
   endtask

   task automatic ar_push(input logic [1:0] id);
      dsp_AR_push_i   = 1'b1;
      dsp_AR_slv_id_i = id;
      cycle();
      dsp_AR_push_i   = 1'b0;
   endtask

   task automatic send(input int k, input beat_t b);
      sa_RVALID_i    = '0;
      sa_RVALID_i[k] = 1'b1;
      in_beat[k]     = b;
      cycle();
      sa_RVALID_i    = '0;
   endtask

   task automatic do_reset();
      ARESET_i = 1'b1;
      cycle();
      ARESET_i = 1'b0;
   endtask

   int  c0;
   int  acc;
   logic took;

   initial begin
      ARESET_i        = 1'b1;
      dsp_AR_push_i   = 1'b0;
      dsp_AR_slv_id_i = '0;
      dsp_R_disable_i = 1'b0;
      sa_RVALID_i     = '0;
      m_RREADY_i      = 1'b0;
      for (int k = 0; k < SLV; k++)
         in_beat[k] = '0;
      clear_got();
      @(posedge clk);
      @(negedge clk);
      model_reset();

      chk("rst_rvalid", m_RVALID_o, 0);
      chk("rst_beat", {m_RID_o, m_RDATA_o, m_RRESP_o, m_RLAST_o}, 0);
      chk("rst_outst", dsp_R_outstanding_o, 0);
      chk("rst_arready", dsp_AR_ready_o, 1);
      chk("rst_rready", sa_RREADY_o, 4'hF);
      chk("rst_hs", dsp_R_handshake_occur_o, 0);
      chk("rst_ldone", dsp_R_last_done_o, 0);
      cycle();
      ARESET_i = 1'b0;

      // single slave burst
      clear_got();
      m_RREADY_i = 1'b1;
      ar_push(2'd1);
      chk("s1_outst1", dsp_R_outstanding_o, 1);
      c0 = cyc;
      for (int i = 0; i < 4; i++)
         send(1, mk(5'd3, 64'(16 + i), 2'd0, i == 3));
      repeat (4) cycle();
      chk("s1_n", got_d.size(), 4);
      for (int i = 0; i < got_d.size() && i < 4; i++)
         chk("s1_data", got_d[i], 64'(16 + i));
      if (got_c.size() == 4) begin
         chk("s1_lat", got_c[0] - c0, 2);
         chk("s1_b2b", got_c[3] - got_c[0], 3);
      end
      chk("s1_last", n_last, 1);
      chk("s1_outst0", dsp_R_outstanding_o, 0);

      // out-of-order return delivered in AR order
      clear_got();
      ar_push(2'd2);
      ar_push(2'd0);
      send(0, mk(5'd1, 64'hA0, 2'd1, 1'b0));
      send(0, mk(5'd1, 64'hA1, 2'd1, 1'b1));
      send(2, mk(5'd2, 64'hB0, 2'd0, 1'b0));
      send(2, mk(5'd2, 64'hB1, 2'd0, 1'b1));
      repeat (6) cycle();
      chk("ooo_n", got_d.size(), 4);
      if (got_d.size() == 4) begin
         chk("ooo_d0", got_d[0], 64'hB0);
         chk("ooo_d1", got_d[1], 64'hB1);
         chk("ooo_d2", got_d[2], 64'hA0);
         chk("ooo_d3", got_d[3], 64'hA1);
         chk("ooo_gap", got_c[2] - got_c[1], 1);
      end

      // backpressure on slave 3
      clear_got();
      m_RREADY_i = 1'b0;
      ar_push(2'd3);
      acc = 0;
      for (int i = 0; i < 30; i++) begin
         sa_RVALID_i = 4'b1000;
         in_beat[3]  = mk(5'd7, 64'(acc), 2'd1, acc == 19);
         took        = sa_RREADY_o[3];
         cycle();
         if (took)
            acc++;
      end
      chk("bp_acc", acc, 17);
      chk("bp_rdy3", sa_RREADY_o[3], 0);
      m_RREADY_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sa_RVALID_i = (acc < 20) ? 4'b1000 : 4'b0000;
         in_beat[3]  = mk(5'd7, 64'(acc), 2'd1, acc == 19);
         took        = sa_RREADY_o[3] && (acc < 20);
         cycle();
         if (took)
            acc++;
      end
      sa_RVALID_i = '0;
      chk("bp_n", got_d.size(), 20);
      for (int i = 0; i < got_d.size() && i < 20; i++)
         chk("bp_data", got_d[i], 64'(i));
      chk("bp_last", n_last, 1);

      // order queue full
      for (int i = 0; i < 8; i++)
         ar_push(2'd0);
      chk("of_arready", dsp_AR_ready_o, 0);
      chk("of_outst8", dsp_R_outstanding_o, 8);
      ar_push(2'd1);
      chk("of_ignored", dsp_R_outstanding_o, 8);
      send(0, mk(5'd4, 64'hC0, 2'd0, 1'b1));
      cycle();
      chk("of_outst7", dsp_R_outstanding_o, 7);
      send(0, mk(5'd4, 64'hC1, 2'd0, 1'b1));
      ar_push(2'd2);
      chk("of_pushpop", dsp_R_outstanding_o, 7);
      do_reset();

      // stall via disable, then release
      clear_got();
      ar_push(2'd2);
      dsp_R_disable_i = 1'b1;
      send(2, mk(5'd9, 64'hD0, 2'd2, 1'b0));
      send(2, mk(5'd9, 64'hD1, 2'd2, 1'b1));
      for (int i = 0; i < 4; i++) begin
         chk("dis_rvalid", m_RVALID_o, 0);
         cycle();
      end
      dsp_R_disable_i = 1'b0;
      repeat (5) cycle();
      chk("dis_n", got_d.size(), 2);
      if (got_d.size() == 2) begin
         chk("dis_d0", got_d[0], 64'hD0);
         chk("dis_d1", got_d[1], 64'hD1);
      end

      // reset in the middle of a burst
      m_RREADY_i = 1'b0;
      ar_push(2'd1);
      send(1, mk(5'd6, 64'hE0, 2'd0, 1'b0));
      send(1, mk(5'd6, 64'hE1, 2'd0, 1'b0));
      cycle();
      chk("mr_pre", m_RVALID_o, 1);
      do_reset();
      chk("mr_rvalid", m_RVALID_o, 0);
      chk("mr_outst", dsp_R_outstanding_o, 0);
      chk("mr_rready", sa_RREADY_o, 4'hF);
      chk("mr_arready", dsp_AR_ready_o, 1);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         ARESET_i        = ($urandom % 400) == 0;
         dsp_AR_push_i   = ($urandom % 3) == 0;
         dsp_AR_slv_id_i = 2'($urandom % 4);
         dsp_R_disable_i = ($urandom % 10) == 0;
         m_RREADY_i      = ($urandom % 10) < 7;
         for (int k = 0; k < SLV; k++) begin
            sa_RVALID_i[k] = $urandom % 2;
            in_beat[k] = mk(5'($urandom), {$urandom, $urandom},
                            2'($urandom), ($urandom % 3) == 0);
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
